// File: rtl/axi_lite_sram.sv
// rtl/axi_lite_sram.sv - AXI-lite slave word memory with programmable read/write latency
// Independent read and write FSMs share one word array and one latency-jitter LFSR.
module axi_lite_sram #(
  parameter int                 ADDR_W      = 32,
  parameter int                 DATA_W      = 32,
  parameter int                 DEPTH_WORDS = 4096,
  parameter logic [ADDR_W-1:0]  BASE_ADDR   = 32'h8000_0000,
  parameter int                 RD_LAT      = 1,
  parameter int                 WR_LAT      = 1,
  parameter int                 RAND_EN     = 0,
  parameter logic [7:0]         LFSR_SEED   = 8'hA5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              slv_ar_valid_i,
  input  logic [ADDR_W-1:0] slv_ar_addr_i,
  output logic              slv_ar_ready_o,
  output logic              slv_r_valid_o,
  output logic [DATA_W-1:0] slv_r_data_o,
  output logic [1:0]        slv_r_resp_o,
  input  logic              slv_r_ready_i,
  input  logic              slv_aw_valid_i,
  input  logic [ADDR_W-1:0] slv_aw_addr_i,
  output logic              slv_aw_ready_o,
  input  logic              slv_w_valid_i,
  input  logic [DATA_W-1:0] slv_w_data_i,
  input  logic [3:0]        slv_w_strb_i,
  output logic              slv_w_ready_o,
  output logic              slv_b_valid_o,
  output logic [1:0]        slv_b_resp_o,
  input  logic              slv_b_ready_i
);

  localparam int                IDX_W = $clog2(DEPTH_WORDS);
  localparam int                CNT_W = 8;
  localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(4 * DEPTH_WORDS);
  localparam logic [1:0]        RESP_OKAY   = 2'b00;
  localparam logic [1:0]        RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    R_IDLE = 3'b001,
    R_WAIT = 3'b010,
    R_RESP = 3'b100
  } r_state_t;

  typedef enum logic [2:0] {
    W_IDLE = 3'b001,
    W_WAIT = 3'b010,
    W_RESP = 3'b100
  } w_state_t;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic [7:0] lfsr;
  logic       lfsr_fb;
  logic [2:0] rnd;

  r_state_t          r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic              r_ok;
  logic              ar_ready_q;
  logic              r_valid_q;
  logic [DATA_W-1:0] r_data_q;
  logic [1:0]        r_resp_q;

  w_state_t          w_state;
  logic [CNT_W-1:0]  w_cnt;
  logic [IDX_W-1:0]  w_idx;
  logic              w_ok;
  logic [DATA_W-1:0] w_data_q;
  logic [3:0]        w_strb_q;
  logic              aw_held;
  logic              w_held;
  logic              aw_ready_q;
  logic              w_ready_q;
  logic              b_valid_q;
  logic [1:0]        b_resp_q;

  logic [ADDR_W-1:0] ar_off;
  logic [ADDR_W-1:0] aw_off;
  logic              ar_hs;
  logic              aw_hs;
  logic              w_hs;
  logic              aw_got;
  logic              w_got;
  logic              wr_commit;

  // Offsets wrap modulo 2^ADDR_W, so addresses below BASE_ADDR land far above SPAN.
  assign ar_off  = slv_ar_addr_i - BASE_ADDR;
  assign aw_off  = slv_aw_addr_i - BASE_ADDR;
  assign ar_hs   = slv_ar_valid_i & ar_ready_q;
  assign aw_hs   = slv_aw_valid_i & aw_ready_q;
  assign w_hs    = slv_w_valid_i & w_ready_q;
  assign aw_got  = aw_held | aw_hs;
  assign w_got   = w_held | w_hs;

  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign rnd     = (RAND_EN != 0) ? lfsr[2:0] : 3'd0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[6:0], lfsr_fb};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= R_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_ok       <= 1'b0;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
      r_resp_q   <= '0;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          ar_ready_q <= 1'b1;
          if (ar_hs) begin
            r_idx      <= ar_off[IDX_W+1:2];
            r_ok       <= (ar_off < SPAN);
            r_cnt      <= CNT_W'(RD_LAT - 1) + CNT_W'(rnd);
            ar_ready_q <= 1'b0;
            r_state    <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_cnt == '0) begin
            // Sampled before this edge's write commit, so a colliding write is not visible.
            r_data_q  <= r_ok ? mem[r_idx] : '0;
            r_resp_q  <= r_ok ? RESP_OKAY : RESP_DECERR;
            r_valid_q <= 1'b1;
            r_state   <= R_RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        R_RESP: begin
          if (slv_r_ready_i) begin
            r_valid_q  <= 1'b0;
            ar_ready_q <= 1'b1;
            r_state    <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state    <= W_IDLE;
      w_cnt      <= '0;
      w_idx      <= '0;
      w_ok       <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= '0;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_held <= 1'b1;
            w_idx   <= aw_off[IDX_W+1:2];
            w_ok    <= (aw_off < SPAN);
          end
          if (w_hs) begin
            w_held   <= 1'b1;
            w_data_q <= slv_w_data_i;
            w_strb_q <= slv_w_strb_i;
          end
          if (aw_got && w_got) begin
            w_cnt      <= CNT_W'(WR_LAT - 1) + CNT_W'(rnd);
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            w_state    <= W_WAIT;
          end else begin
            aw_ready_q <= ~aw_got;
            w_ready_q  <= ~w_got;
          end
        end
        W_WAIT: begin
          if (w_cnt == '0) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            b_valid_q <= 1'b1;
            b_resp_q  <= w_ok ? RESP_OKAY : RESP_DECERR;
            w_state   <= W_RESP;
          end else begin
            w_cnt <= w_cnt - CNT_W'(1);
          end
        end
        W_RESP: begin
          if (slv_b_ready_i) begin
            b_valid_q  <= 1'b0;
            aw_ready_q <= 1'b1;
            w_ready_q  <= 1'b1;
            w_state    <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  assign wr_commit = (w_state == W_WAIT) && (w_cnt == '0) && w_ok && !rst_i;

  always_ff @(posedge clk_i) begin
    if (wr_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb_q[b]) begin
          mem[w_idx][8*b +: 8] <= w_data_q[8*b +: 8];
        end
      end
    end
  end

  assign slv_ar_ready_o = ar_ready_q;
  assign slv_r_valid_o  = r_valid_q;
  assign slv_r_data_o   = r_data_q;
  assign slv_r_resp_o   = r_resp_q;
  assign slv_aw_ready_o = aw_ready_q;
  assign slv_w_ready_o  = w_ready_q;
  assign slv_b_valid_o  = b_valid_q;
  assign slv_b_resp_o   = b_resp_q;

endmodule

// File: tb/tb_axi_lite_sram.sv
// tb/tb_axi_lite_sram.sv - scoreboard bench for axi_lite_sram (fixed-latency and random-latency instances)
module tb_axi_lite_sram;

  localparam logic [31:0] BASE = 32'h8000_0000;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    int          ar_cyc;
    int          lmin;
    int          lmax;
  } rexp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ar_valid [2];
  logic [31:0] ar_addr  [2];
  logic        ar_ready [2];
  logic        r_valid  [2];
  logic [31:0] r_data   [2];
  logic [1:0]  r_resp   [2];
  logic        r_ready  [2];
  logic        aw_valid [2];
  logic [31:0] aw_addr  [2];
  logic        aw_ready [2];
  logic        w_valid  [2];
  logic [31:0] w_data   [2];
  logic [3:0]  w_strb   [2];
  logic        w_ready  [2];
  logic        b_valid  [2];
  logic [1:0]  b_resp   [2];
  logic        b_ready  [2];

  rexp_t       rq0 [$];
  rexp_t       rq1 [$];
  logic [1:0]  bq0 [$];
  logic [1:0]  bq1 [$];
  logic [31:0] m1 [8];

  int  cyc = 0;
  int  nchk = 0;
  int  nerr = 0;
  int  fv [2];
  bit  seen [2];
  bit  rand_rr = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi_lite_sram dut0 (
    .clk_i(clk), .rst_i(rst),
    .slv_ar_valid_i(ar_valid[0]), .slv_ar_addr_i(ar_addr[0]), .slv_ar_ready_o(ar_ready[0]),
    .slv_r_valid_o(r_valid[0]), .slv_r_data_o(r_data[0]), .slv_r_resp_o(r_resp[0]),
    .slv_r_ready_i(r_ready[0]),
    .slv_aw_valid_i(aw_valid[0]), .slv_aw_addr_i(aw_addr[0]), .slv_aw_ready_o(aw_ready[0]),
    .slv_w_valid_i(w_valid[0]), .slv_w_data_i(w_data[0]), .slv_w_strb_i(w_strb[0]),
    .slv_w_ready_o(w_ready[0]),
    .slv_b_valid_o(b_valid[0]), .slv_b_resp_o(b_resp[0]), .slv_b_ready_i(b_ready[0])
  );

  axi_lite_sram #(.RAND_EN(1)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .slv_ar_valid_i(ar_valid[1]), .slv_ar_addr_i(ar_addr[1]), .slv_ar_ready_o(ar_ready[1]),
    .slv_r_valid_o(r_valid[1]), .slv_r_data_o(r_data[1]), .slv_r_resp_o(r_resp[1]),
    .slv_r_ready_i(r_ready[1]),
    .slv_aw_valid_i(aw_valid[1]), .slv_aw_addr_i(aw_addr[1]), .slv_aw_ready_o(aw_ready[1]),
    .slv_w_valid_i(w_valid[1]), .slv_w_data_i(w_data[1]), .slv_w_strb_i(w_strb[1]),
    .slv_w_ready_o(w_ready[1]),
    .slv_b_valid_o(b_valid[1]), .slv_b_resp_o(b_resp[1]), .slv_b_ready_i(b_ready[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    nchk++;
    nerr++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic chk_r(input int d, input rexp_t e, input int first_valid);
    int lat;
    lat = first_valid - e.ar_cyc;
    chk($sformatf("r%0d_data", d), r_data[d], e.data);
    chk($sformatf("r%0d_resp", d), 32'(r_resp[d]), 32'(e.resp));
    chk($sformatf("r%0d_latency", d), (lat >= e.lmin && lat <= e.lmax) ? e.lmin : lat, e.lmin);
  endtask

  // Scoreboard monitor: pops one expected entry per R or B handshake.
  always @(negedge clk) begin
    if (rst) begin
      seen[0] = 1'b0;
      seen[1] = 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (r_valid[d] && !seen[d]) begin
          seen[d] = 1'b1;
          fv[d]   = cyc;
        end
      end
      if (r_valid[0] && r_ready[0]) begin
        seen[0] = 1'b0;
        if (rq0.size() == 0) fail_now("r0_unexpected");
        else chk_r(0, rq0.pop_front(), fv[0]);
      end
      if (r_valid[1] && r_ready[1]) begin
        seen[1] = 1'b0;
        if (rq1.size() == 0) fail_now("r1_unexpected");
        else chk_r(1, rq1.pop_front(), fv[1]);
      end
      if (b_valid[0] && b_ready[0]) begin
        if (bq0.size() == 0) fail_now("b0_unexpected");
        else chk("b0_resp", 32'(b_resp[0]), 32'(bq0.pop_front()));
      end
      if (b_valid[1] && b_ready[1]) begin
        if (bq1.size() == 0) fail_now("b1_unexpected");
        else chk("b1_resp", 32'(b_resp[1]), 32'(bq1.pop_front()));
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      r_ready[1] = rand_rr ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic rd(input int d, input logic [31:0] addr, input logic [31:0] data,
                    input logic [1:0] resp, input int lmin, input int lmax);
    rexp_t e;
    int n = 0;
    ar_valid[d] = 1'b1;
    ar_addr[d]  = addr;
    @(negedge clk);
    while (!ar_ready[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ar_ready[d]) begin
      fail_now($sformatf("ar%0d_timeout", d));
    end else begin
      e.data = data; e.resp = resp; e.ar_cyc = cyc; e.lmin = lmin; e.lmax = lmax;
      if (d == 0) rq0.push_back(e);
      else rq1.push_back(e);
    end
    @(posedge clk);
    #1;
    ar_valid[d] = 1'b0;
  endtask

  task automatic wr(input int d, input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] strb, input int w_dly, input int aw_dly,
                    input logic [1:0] resp);
    int k = 0;
    bit wd = 1'b0;
    bit ad = 1'b0;
    bit wgo, ago;
    if (d == 0) bq0.push_back(resp);
    else bq1.push_back(resp);
    while (!(wd && ad) && k < 200) begin
      if (k == w_dly && !wd) begin
        w_valid[d] = 1'b1; w_data[d] = data; w_strb[d] = strb;
      end
      if (k == aw_dly && !ad) begin
        aw_valid[d] = 1'b1; aw_addr[d] = addr;
      end
      @(negedge clk);
      wgo = w_valid[d] && w_ready[d];
      ago = aw_valid[d] && aw_ready[d];
      @(posedge clk);
      #1;
      if (wgo) begin w_valid[d] = 1'b0; wd = 1'b1; end
      if (ago) begin aw_valid[d] = 1'b0; ad = 1'b1; end
      k++;
    end
    if (!(wd && ad)) begin
      fail_now($sformatf("wr%0d_timeout", d));
      w_valid[d]  = 1'b0;
      aw_valid[d] = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((rq0.size() + rq1.size() + bq0.size() + bq1.size()) != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (n >= 400) fail_now("idle_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin
    int vcnt;
    int idx;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      ar_valid[d] = 1'b0; ar_addr[d] = '0;
      aw_valid[d] = 1'b0; aw_addr[d] = '0;
      w_valid[d]  = 1'b0; w_data[d]  = '0; w_strb[d] = '0;
      b_ready[d]  = 1'b1;
    end
    r_ready[0] = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ar_ready", ar_ready[0], 0);
    chk("rst_aw_ready", aw_ready[0], 0);
    chk("rst_w_ready", w_ready[0], 0);
    chk("rst_r_valid", r_valid[0], 0);
    chk("rst_b_valid", b_valid[0], 0);
    chk("rst_r_data", r_data[0], 0);
    chk("rst_r_resp", 32'(r_resp[0]), 0);
    chk("rst_b_resp", 32'(b_resp[0]), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_ar_ready", ar_ready[0], 1);
    chk("post_rst_aw_ready", aw_ready[0], 1);
    chk("post_rst_w_ready", w_ready[0], 1);
    @(posedge clk);
    #1;

    wr(0, BASE, 32'h0000_0413, 4'hF, 0, 0, 2'b00);
    wr(0, BASE + 32'h10, 32'h0, 4'hF, 0, 0, 2'b00);
    wait_idle();
    rd(0, BASE, 32'h0000_0413, 2'b00, 2, 2);
    wait_idle();

    // Response must hold steady while r_ready is low; addr[1:0] is ignored.
    r_ready[0] = 1'b0;
    rd(0, BASE + 32'h2, 32'h0000_0413, 2'b00, 2, 2);
    vcnt = 0;
    @(negedge clk);
    while (!r_valid[0] && vcnt < 20) begin
      @(negedge clk);
      vcnt++;
    end
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clk);
      chk("hold_r_valid", r_valid[0], 1);
      chk("hold_r_data", r_data[0], 32'h0000_0413);
      chk("hold_r_resp", 32'(r_resp[0]), 0);
      chk("hold_ar_ready", ar_ready[0], 0);
    end
    @(posedge clk);
    #1 r_ready[0] = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("after_rhs_ar_ready", ar_ready[0], 1);
    chk("after_rhs_r_valid", r_valid[0], 0);
    @(posedge clk);
    #1;

    wr(0, BASE + 32'h10, 32'hDEAD_BEEF, 4'b0101, 0, 3, 2'b00);
    wait_idle();
    rd(0, BASE + 32'h10, 32'h00AD_00EF, 2'b00, 2, 2);
    wait_idle();

    wr(0, BASE + 32'h14, 32'h1234_5678, 4'hF, 2, 0, 2'b00);
    wr(0, BASE + 32'h14, 32'hAABB_CCDD, 4'b0010, 0, 0, 2'b00);
    wr(0, BASE + 32'h14, 32'hFFFF_FFFF, 4'b0000, 1, 1, 2'b00);
    wait_idle();
    rd(0, BASE + 32'h14, 32'h1234_CC78, 2'b00, 2, 2);
    wait_idle();

    rd(0, 32'h7FFF_FFFC, 32'h0, 2'b11, 2, 2);
    wait_idle();
    rd(0, 32'h8000_4000, 32'h0, 2'b11, 2, 2);
    wait_idle();
    wr(0, 32'h8000_4000, 32'hFFFF_FFFF, 4'hF, 0, 0, 2'b11);
    wait_idle();
    rd(0, BASE, 32'h0000_0413, 2'b00, 2, 2);
    wait_idle();

    // Reset lands while both FSMs are in their wait states; the write must be dropped.
    ar_valid[0] = 1'b1; ar_addr[0] = BASE;
    aw_valid[0] = 1'b1; aw_addr[0] = BASE;
    w_valid[0]  = 1'b1; w_data[0]  = 32'hBAD0_BAD0; w_strb[0] = 4'hF;
    @(negedge clk);
    chk("pre_rst_ar_ready", ar_ready[0], 1);
    chk("pre_rst_aw_ready", aw_ready[0], 1);
    chk("pre_rst_w_ready", w_ready[0], 1);
    @(posedge clk);
    #1;
    ar_valid[0] = 1'b0; aw_valid[0] = 1'b0; w_valid[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_ar_ready", ar_ready[0], 0);
    chk("midrst_aw_ready", aw_ready[0], 0);
    chk("midrst_w_ready", w_ready[0], 0);
    chk("midrst_r_valid", r_valid[0], 0);
    chk("midrst_b_valid", b_valid[0], 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rel_ar_ready", ar_ready[0], 1);
    chk("rel_aw_ready", aw_ready[0], 1);
    chk("rel_w_ready", w_ready[0], 1);
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (r_valid[0] || b_valid[0]) vcnt++;
    end
    chk("stale_valid_cycles", vcnt, 0);
    @(posedge clk);
    #1;
    rd(0, BASE, 32'h0000_0413, 2'b00, 2, 2);
    wait_idle();

    rand_rr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      m1[i] = 32'hA000_0000 + 32'(i) * 32'h0101_0101;
      wr(1, BASE + 32'(4 * i), m1[i], 4'hF, 0, 0, 2'b00);
    end
    wait_idle();
    for (int k = 0; k < 200; k++) begin
      idx = $urandom_range(0, 7);
      rd(1, BASE + 32'(4 * idx), m1[idx], 2'b00, 2, 9);
    end
    wait_idle();
    rand_rr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
